// File: rtl/gmii_tx_framer.sv
// Byte-stream to GMII transmit framer: preamble/SFD insertion, padding, IFG, abort handling.
// Optional CRC-32 FCS append when GMII_TX_FCS_EN is defined.
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_BYTES    = 12,
    parameter int MIN_FRAME    = 60,
    parameter int MAX_FRAME    = 1514
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    input  logic       s_err,
    output logic       s_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       underrun,
    output logic       truncated
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_DROP, ST_IFG
    } state_t;

    localparam logic [3:0]  PRE_LEN     = 4'(PREAMBLE_LEN);
    localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME);
    localparam logic [8:0]  IFG_LEN     = 9'(IFG_BYTES);
    localparam logic [8:0]  IFG_LEN_ERR = 9'(IFG_BYTES + 1);

    state_t      state_q;
    logic [3:0]  pre_cnt_q;
    logic [15:0] byte_cnt_q;
    logic [8:0]  ifg_cnt_q;
    logic [7:0]  txd_q;
    logic        tx_en_q, tx_er_q, s_ready_q, underrun_q, truncated_q;

`ifdef GMII_TX_FCS_EN
    logic [31:0] crc_q;
    logic [2:0]  fcs_idx_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction
`endif

    // The state names the phase in which input is consumed; the output
    // registers lag by one cycle, so each branch loads what shows next cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, and the
        // reset branch is synchronous, so it is sampled on the clock edge.
        if (rst) begin
            state_q     <= ST_IDLE;
            pre_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            ifg_cnt_q   <= '0;
            txd_q       <= '0;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            s_ready_q   <= 1'b0;
            underrun_q  <= 1'b0;
            truncated_q <= 1'b0;
`ifdef GMII_TX_FCS_EN
            crc_q       <= '1;
            fcs_idx_q   <= '0;
`endif
        end else begin
            underrun_q  <= 1'b0;
            truncated_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        state_q    <= ST_PREAMBLE;
                        txd_q      <= 8'h55;
                        tx_en_q    <= 1'b1;
                        tx_er_q    <= 1'b0;
                        pre_cnt_q  <= 4'd1;
                        byte_cnt_q <= '0;
`ifdef GMII_TX_FCS_EN
                        crc_q      <= '1;
`endif
                    end
                end
                ST_PREAMBLE: begin
                    if (pre_cnt_q == PRE_LEN) begin
                        state_q   <= ST_SFD;
                        txd_q     <= 8'hD5;
                        s_ready_q <= 1'b1;
                    end else begin
                        pre_cnt_q <= pre_cnt_q + 4'd1;
                    end
                end
                ST_SFD, ST_DATA: begin
                    if (!s_valid) begin
                        state_q    <= ST_DROP;
                        txd_q      <= 8'h00;
                        tx_er_q    <= 1'b1;
                        underrun_q <= 1'b1;
                        ifg_cnt_q  <= IFG_LEN_ERR;
                    end else if (byte_cnt_q == MAX_LEN) begin
                        txd_q       <= s_data;
                        tx_er_q     <= 1'b1;
                        truncated_q <= 1'b1;
                        ifg_cnt_q   <= IFG_LEN_ERR;
                        if (s_last) begin
                            state_q   <= ST_IFG;
                            s_ready_q <= 1'b0;
                        end else begin
                            state_q   <= ST_DROP;
                        end
                    end else begin
                        txd_q      <= s_data;
                        tx_er_q    <= s_err;
                        byte_cnt_q <= byte_cnt_q + 16'd1;
`ifdef GMII_TX_FCS_EN
                        crc_q      <= crc_byte(crc_q, s_data);
`endif
                        // PAD also serves as the one-cycle tail that shows the last byte.
                        if (s_last) begin
                            state_q   <= ST_PAD;
                            s_ready_q <= 1'b0;
                        end else begin
                            state_q   <= ST_DATA;
                        end
                    end
                end
                ST_PAD: begin
                    if (byte_cnt_q < MIN_LEN) begin
                        txd_q      <= 8'h00;
                        tx_er_q    <= 1'b0;
                        byte_cnt_q <= byte_cnt_q + 16'd1;
`ifdef GMII_TX_FCS_EN
                        crc_q      <= crc_byte(crc_q, 8'h00);
`endif
                    end else begin
`ifdef GMII_TX_FCS_EN
                        state_q   <= ST_FCS;
                        txd_q     <= ~crc_q[7:0];
                        tx_er_q   <= 1'b0;
                        fcs_idx_q <= 3'd1;
`else
                        state_q   <= ST_IFG;
                        txd_q     <= 8'h00;
                        tx_en_q   <= 1'b0;
                        tx_er_q   <= 1'b0;
                        ifg_cnt_q <= IFG_LEN;
`endif
                    end
                end
`ifdef GMII_TX_FCS_EN
                ST_FCS: begin
                    if (fcs_idx_q == 3'd4) begin
                        state_q   <= ST_IFG;
                        txd_q     <= 8'h00;
                        tx_en_q   <= 1'b0;
                        ifg_cnt_q <= IFG_LEN;
                    end else begin
                        txd_q     <= ~crc_q[{fcs_idx_q[1:0], 3'b000} +: 8];
                        fcs_idx_q <= fcs_idx_q + 3'd1;
                    end
                end
`endif
                ST_DROP: begin
                    txd_q   <= 8'h00;
                    tx_en_q <= 1'b0;
                    tx_er_q <= 1'b0;
                    if (ifg_cnt_q != '0) ifg_cnt_q <= ifg_cnt_q - 9'd1;
                    if (s_valid && s_last) begin
                        state_q   <= ST_IFG;
                        s_ready_q <= 1'b0;
                    end
                end
                ST_IFG: begin
                    txd_q   <= 8'h00;
                    tx_en_q <= 1'b0;
                    tx_er_q <= 1'b0;
                    if (ifg_cnt_q <= 9'd1) state_q <= ST_IDLE;
                    else ifg_cnt_q <= ifg_cnt_q - 9'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign busy       = (state_q != ST_IDLE);
    assign underrun   = underrun_q;
    assign truncated  = truncated_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: expected GMII beats are queued as frames are
// driven and compared against every tx_en cycle the DUT produces.
module tb_gmii_tx_framer;

    localparam int PRE  = 7;
    localparam int IFG  = 12;
    localparam int MINF = 60;
    localparam int MAXF = 1514;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0, s_last = 1'b0, s_err = 1'b0;
    logic       s_ready, gmii_tx_en, gmii_tx_er, busy, underrun, truncated;
    logic [7:0] gmii_txd;

    gmii_tx_framer #(.PREAMBLE_LEN(PRE), .IFG_BYTES(IFG), .MIN_FRAME(MINF), .MAX_FRAME(MAXF)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_err(s_err), .s_ready(s_ready), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er), .busy(busy), .underrun(underrun), .truncated(truncated)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sof;
        logic [7:0] txd;
        logic       er;
        logic       ur;
        logic       tr;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    gap_q[$];
    int    n_checks = 0, n_fail = 0;
    int    idle_bad = 0, idle_run = 0, busy_idle = 0;
    logic  en_prev = 1'b0;

    function automatic beat_t mk(input logic sof, input logic [7:0] d, input logic er,
                                 input logic ur, input logic tr);
        beat_t b;
        b.sof = sof; b.txd = d; b.er = er; b.ur = ur; b.tr = tr;
        return b;
    endfunction

    // Monitor: every tx_en cycle becomes an observed beat; idle cycles must be clean.
    always @(negedge clk) begin
        if (gmii_tx_en) begin
            obs_q.push_back(mk(!en_prev, gmii_txd, gmii_tx_er, underrun, truncated));
            if (!en_prev) gap_q.push_back(idle_run);
            idle_run = 0;
        end else begin
            idle_run++;
            if (busy) busy_idle++;
            if (gmii_txd != 8'h00 || gmii_tx_er || underrun || truncated) idle_bad++;
        end
        en_prev = gmii_tx_en;
    end

`ifdef GMII_TX_FCS_EN
    // Non-reflected shift register fed LSB first; bit-reversed at the end.
    function automatic logic [31:0] crc_step(input logic [31:0] n, input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = n[31] ^ b[i];
            n  = {n[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
        end
        return n;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction
`endif

    task automatic push_hdr();
        for (int i = 0; i < PRE; i++) exp_q.push_back(mk(i == 0, 8'h55, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 8'hD5, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic push_good(input logic [7:0] d[$], input bit e[$]);
`ifdef GMII_TX_FCS_EN
        logic [31:0] n = 32'hFFFF_FFFF;
        logic [31:0] fcs;
`endif
        push_hdr();
        for (int i = 0; i < d.size(); i++) begin
            exp_q.push_back(mk(1'b0, d[i], e[i], 1'b0, 1'b0));
`ifdef GMII_TX_FCS_EN
            n = crc_step(n, d[i]);
`endif
        end
        for (int i = d.size(); i < MINF; i++) begin
            exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
`ifdef GMII_TX_FCS_EN
            n = crc_step(n, 8'h00);
`endif
        end
`ifdef GMII_TX_FCS_EN
        fcs = ~rev32(n);
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b0, fcs[8*k +: 8], 1'b0, 1'b0, 1'b0));
`endif
    endtask

    // Presents bytes with s_valid held; a single-cycle s_valid gap is inserted before byte stall_at.
    task automatic drive(input logic [7:0] d[$], input bit e[$], input int stall_at, output bit ok);
        int   i = 0;
        int   budget = 0;
        bit   stalled = 1'b0;
        logic hs;
        ok = 1'b1;
        while (i < d.size()) begin
            if (i == stall_at && !stalled) begin
                stalled = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
            end else begin
                s_valid = 1'b1; s_data = d[i]; s_err = e[i]; s_last = (i == d.size() - 1);
            end
            hs = s_ready & s_valid;
            @(posedge clk); #1;
            if (hs) i++;
            budget++;
            if (budget > 4000) begin ok = 1'b0; break; end
        end
        s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        for (int k = 0; k < 400 && busy; k++) begin @(posedge clk); #1; end
        ok = !busy;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic make_frame(input int len, input int seed, output logic [7:0] d[$], output bit e[$]);
        d.delete(); e.delete();
        for (int i = 0; i < len; i++) begin d.push_back(8'(i + seed)); e.push_back(1'b0); end
    endtask

    task automatic test_reset();
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if ({gmii_txd, gmii_tx_en, gmii_tx_er, s_ready, busy, underrun, truncated} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got txd=%h en=%b er=%b rdy=%b busy=%b ur=%b tr=%b, expected all 0",
                     gmii_txd, gmii_tx_en, gmii_tx_er, s_ready, busy, underrun, truncated);
        end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if ({gmii_tx_en, busy, s_ready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle: got en=%b busy=%b rdy=%b, expected 000", gmii_tx_en, busy, s_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d[$]; bit e[$]; bit ok; beat_t ex, ob;
        exp_q.delete(); obs_q.delete();
        make_frame(64, 0, d, e);
        push_good(d, e);
        busy_idle = 0;
        drive(d, e, -1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_drive: got timeout, expected all bytes accepted"); end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_idle: got busy=1, expected return to idle"); end
        n_checks++;
        if (busy_idle !== IFG) begin n_fail++; $display("FAIL basic_ifg: got %0d idle busy cycles, expected %0d", busy_idle, IFG); end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL basic_beat: got nothing, expected %h", ex);
            end else begin
                ob = obs_q.pop_front();
                if (ob !== ex) begin n_fail++; $display("FAIL basic_beat: got %h, expected %h", ob, ex); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL basic_extra: got %0d extra beats, expected 0", obs_q.size()); end
    endtask

    task automatic test_pad();
        logic [7:0] d[$]; bit e[$]; bit ok; beat_t ex, ob;
        int lens[3] = '{10, 59, 60};
        exp_q.delete(); obs_q.delete();
        foreach (lens[j]) begin
            make_frame(lens[j], (j == 2) ? 0 : 8'h80 + j, d, e);
            if (j == 2) foreach (d[i]) d[i] = 8'h00;
            if (j == 0) e[3] = 1'b1;
            push_good(d, e);
            drive(d, e, -1, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL pad_drive: got timeout on len %0d, expected accepted", lens[j]); end
            wait_idle(ok);
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL pad_beat: got nothing, expected %h", ex);
            end else begin
                ob = obs_q.pop_front();
                if (ob !== ex) begin n_fail++; $display("FAIL pad_beat: got %h, expected %h", ob, ex); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL pad_extra: got %0d extra beats, expected 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1[$], d2[$]; bit e1[$], e2[$]; bit ok1, ok2, ok; beat_t ex, ob;
        exp_q.delete(); obs_q.delete(); gap_q.delete();
        make_frame(64, 8'h10, d1, e1);
        make_frame(20, 8'hA0, d2, e2);
        push_good(d1, e1);
        push_good(d2, e2);
        drive(d1, e1, -1, ok1);
        drive(d2, e2, -1, ok2);
        wait_idle(ok);
        n_checks++;
        if (!(ok1 && ok2 && ok)) begin n_fail++; $display("FAIL b2b_drive: got timeout, expected completion"); end
        n_checks++;
        if (gap_q.size() != 2 || gap_q[1] != IFG + 1) begin
            n_fail++; $display("FAIL b2b_gap: got %0d gaps (last %0d), expected gap %0d",
                               gap_q.size(), (gap_q.size() > 0) ? gap_q[$] : -1, IFG + 1);
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_beat: got nothing, expected %h", ex);
            end else begin
                ob = obs_q.pop_front();
                if (ob !== ex) begin n_fail++; $display("FAIL b2b_beat: got %h, expected %h", ob, ex); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra beats, expected 0", obs_q.size()); end
    endtask

    task automatic test_underrun();
        logic [7:0] d1[$], d2[$]; bit e1[$], e2[$]; bit ok1, ok2, ok; beat_t ex, ob;
        exp_q.delete(); obs_q.delete(); gap_q.delete();
        make_frame(40, 8'h30, d1, e1);
        make_frame(10, 8'hC0, d2, e2);
        push_hdr();
        for (int i = 0; i < 20; i++) exp_q.push_back(mk(1'b0, d1[i], 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
        push_good(d2, e2);
        drive(d1, e1, 20, ok1);
        drive(d2, e2, -1, ok2);
        wait_idle(ok);
        n_checks++;
        if (!(ok1 && ok2 && ok)) begin n_fail++; $display("FAIL underrun_drive: got timeout, expected completion"); end
        n_checks++;
        if (gap_q.size() != 2 || gap_q[1] < IFG + 1) begin
            n_fail++; $display("FAIL underrun_gap: got %0d gaps (last %0d), expected gap >= %0d",
                               gap_q.size(), (gap_q.size() > 0) ? gap_q[$] : -1, IFG + 1);
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL underrun_beat: got nothing, expected %h", ex);
            end else begin
                ob = obs_q.pop_front();
                if (ob !== ex) begin n_fail++; $display("FAIL underrun_beat: got %h, expected %h", ob, ex); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL underrun_extra: got %0d extra beats, expected 0", obs_q.size()); end
    endtask

    task automatic test_truncate();
        logic [7:0] d1[$], d2[$]; bit e1[$], e2[$]; bit ok1, ok2, ok; beat_t ex, ob;
        exp_q.delete(); obs_q.delete();
        make_frame(1600, 0, d1, e1);
        make_frame(12, 8'h5A, d2, e2);
        push_hdr();
        for (int i = 0; i < MAXF; i++) exp_q.push_back(mk(1'b0, d1[i], 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, d1[MAXF], 1'b1, 1'b0, 1'b1));
        push_good(d2, e2);
        drive(d1, e1, -1, ok1);
        drive(d2, e2, -1, ok2);
        wait_idle(ok);
        n_checks++;
        if (!(ok1 && ok2 && ok)) begin n_fail++; $display("FAIL trunc_drive: got timeout, expected completion"); end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL trunc_beat: got nothing, expected %h", ex);
            end else begin
                ob = obs_q.pop_front();
                if (ob !== ex) begin n_fail++; $display("FAIL trunc_beat: got %h, expected %h", ob, ex); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL trunc_extra: got %0d extra beats, expected 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d[$], d2[$]; bit e[$], e2[$]; bit ok; beat_t ex, ob;
        int i = 0;
        int budget = 0;
        logic hs;
        exp_q.delete(); obs_q.delete();
        make_frame(64, 8'h40, d, e);
        make_frame(10, 8'hE0, d2, e2);
        push_hdr();
        for (int k = 0; k < 30; k++) exp_q.push_back(mk(1'b0, d[k], 1'b0, 1'b0, 1'b0));
        while (i < 30 && budget < 200) begin
            s_valid = 1'b1; s_data = d[i]; s_last = 1'b0;
            hs = s_ready;
            @(posedge clk); #1;
            if (hs) i++;
            budget++;
        end
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({gmii_txd, gmii_tx_en, gmii_tx_er, s_ready, busy, underrun, truncated} !== 14'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got txd=%h en=%b er=%b rdy=%b busy=%b, expected all 0",
                     gmii_txd, gmii_tx_en, gmii_tx_er, s_ready, busy);
        end
        rst = 1'b0;
        push_good(d2, e2);
        drive(d2, e2, -1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_drive: got timeout, expected accepted"); end
        wait_idle(ok);
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL rstmid_beat: got nothing, expected %h", ex);
            end else begin
                ob = obs_q.pop_front();
                if (ob !== ex) begin n_fail++; $display("FAIL rstmid_beat: got %h, expected %h", ob, ex); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_extra: got %0d extra beats, expected 0", obs_q.size()); end
        n_checks++;
        if (idle_bad != 0) begin n_fail++; $display("FAIL idle_clean: got %0d dirty idle cycles, expected 0", idle_bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_back_to_back();
        test_underrun();
        test_truncate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Byte-stream-to-GMII transmit framer, the parametrised successor to the GMII drive interface.
- Accepts frame payload on a valid/ready/last stream and drives gmii_txd/gmii_tx_en/gmii_tx_er.
- Inserts preamble and SFD, pads to minimum length, enforces the inter-frame gap, and propagates, truncates or aborts errored frames.
- Sits between the MAC TX FIFO and the GMII pins/driver interface.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD (1..15).
- IFG_BYTES, 12, idle cycles (tx_en=0) after each frame (1..255).
- MIN_FRAME, 60, minimum data+pad bytes per frame, FCS excluded (0 disables padding).
- MAX_FRAME, 1514, data bytes allowed before forced truncation (must be > MIN_FRAME, < 65536).

Ports:
- clk  in  1  GMII TX clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- s_data  in  8  payload byte.
- s_valid  in  1  byte valid.
- s_last  in  1  last byte of frame.
- s_err  in  1  byte errored; propagate to tx_er.
- s_ready  out  1  byte accepted when s_valid&s_ready.
- gmii_txd  out  8  GMII transmit data.
- gmii_tx_en  out  1  GMII transmit enable.
- gmii_tx_er  out  1  GMII transmit error.
- busy  out  1  high in any state other than IDLE.
- underrun  out  1  one-cycle pulse on data starvation mid-frame.
- truncated  out  1  one-cycle pulse when MAX_FRAME is exceeded.

Behaviour:
- Reset (sync): state=IDLE; s_ready=0, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, busy=0, underrun=0, truncated=0; counters=0. Reset mid-frame aborts immediately; the next cycle shows tx_en=0, with no IFG enforced.
- All GMII outputs are registered; a byte accepted in cycle n appears on gmii_txd in cycle n+1.
- Byte counter: 16 bits, counts data+pad bytes; cleared on entry to PREAMBLE.
- IDLE: s_ready=0. If s_valid=1, go to PREAMBLE. No byte is consumed.
- PREAMBLE: drive 0x55 with tx_en=1 for PREAMBLE_LEN cycles, then SFD.
- SFD: drive 0xD5 for one cycle; s_ready=1 in this cycle so the first data byte is accepted and appears the next cycle.
- DATA: s_ready=1.
  - Each cycle requires s_valid=1. Drive s_data with tx_en=1 and tx_er=s_err.
  - s_last accepted: if count+1 < MIN_FRAME go to PAD, else go to FCS (feature on) or IFG.
  - s_valid=0 in DATA is an underrun: drive txd=0x00, tx_en=1, tx_er=1 for one cycle; pulse underrun; go to DROP.
  - Count reaching MAX_FRAME without s_last: the next byte is driven with tx_er=1; pulse truncated; go to DROP.
- PAD: s_ready=0; drive 0x00, tx_en=1 until count==MIN_FRAME, then FCS or IFG.
- DROP: tx_en=0; s_ready=1; discard bytes until s_last is accepted (if s_last arrived in the triggering cycle, skip DROP). Then go to IFG. The IFG counter runs concurrently in DROP; IFG ends after the remaining cycles.
- IFG: tx_en=0, tx_er=0, txd=0x00, s_ready=0 for IFG_BYTES cycles counted from the first tx_en=0 cycle, then IDLE.
- Back-to-back frames: the IDLE cycle between IFG and PREAMBLE is included; minimum gap between frames is IFG_BYTES+1 cycles.
- s_err on a byte in PREAMBLE/SFD is impossible (s_ready=0 there). s_err is ignored in DROP.

Optional Feature:
- GMII_TX_FCS_EN defined: FCS state appends 4 bytes after DATA/PAD, tx_en=1.
  - CRC-32 (poly 0x04C11DB7, reflected), init 0xFFFFFFFF, over data+pad bytes.
  - Transmitted complemented, LSB byte first.
  - Aborted frames (underrun/truncation) get no FCS.
  - s_err frames still get a normal FCS, with tx_er marking the bad byte.
- Undefined: no CRC logic; DATA/PAD go directly to IFG.

Test Plan:
- 64-byte frame 0x00..0x3F, s_valid continuous -> exact txd sequence:
  - 7×0x55, 0xD5, then 0x00..0x3F;
  - tx_en high for 72 cycles (76 with FCS), tx_er=0;
  - then 12 idle cycles.
- 10-byte frame -> 10 data bytes then 50×0x00 pad; with FCS_EN, a 60-byte frame of all-zero payload ends in 4 FCS bytes matching the reference CRC model.
- Two frames presented back to back -> gap between tx_en falling and next 0x55 is exactly 13 cycles.
- s_valid dropped after data byte 20 -> one cycle with txd=0x00, tx_er=1; underrun pulse; tx_en=0 next cycle; remaining input discarded to s_last; next frame starts after IFG.
- 1600-byte input with MAX_FRAME=1514 -> byte 1515 driven with tx_er=1; truncated pulse; no FCS; the remaining 85 bytes consumed with tx_en=0.
- Assert rst during DATA byte 30 -> next cycle all outputs are at reset values and busy=0; a new frame transmits correctly.
